// File: rtl/serial_word_transmitter.sv
// rtl/serial_word_transmitter.sv - frame-based parallel-to-serial transmitter
// Sends start bit, WIDTH data bits LSB first, parity bit and stop bit, one bit per En tick.
module serial_word_transmitter #(
  parameter int WIDTH      = 32,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Start,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             Busy,
  output logic             SerOut,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             ser_q, ser_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Acceptance ignores En so the frame starts as soon as the request is seen.
        if (Start) begin
          state_d  = START;
          shift_d  = Din;
          parity_d = (^Din) ^ PARITY_ODD;
          cnt_d    = '0;
        end
      end
      START: begin
        if (En) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (En) begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = PARITY;
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (En) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (En) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level and handshake flags are derived from the next state so they are registered.
  always_comb begin
    ser_d = 1'b1;
    case (state_d)
      IDLE:    ser_d = 1'b1;
      START:   ser_d = 1'b0;
      DATA:    ser_d = shift_d[0];
      PARITY:  ser_d = parity_d;
      STOP:    ser_d = 1'b1;
      default: ser_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      ser_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      ser_q    <= ser_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Ready  = ready_q;
  assign Busy   = busy_q;
  assign SerOut = ser_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// tb/tb_serial_word_transmitter.sv - self-checking bench for serial_word_transmitter
// Even- and odd-parity instances share stimulus and are checked against a bit-position model.
module tb_serial_word_transmitter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         start;
  logic [W-1:0] din;

  logic ready_e, busy_e, ser_e, done_e;
  logic ready_o, busy_o, ser_o, done_o;

  always #5 clk = ~clk;

  serial_word_transmitter #(.WIDTH(W), .PARITY_ODD(1'b0)) dut_e (
    .Clk(clk), .Reset(reset), .En(en), .Start(start), .Din(din),
    .Ready(ready_e), .Busy(busy_e), .SerOut(ser_e), .Done(done_e)
  );

  serial_word_transmitter #(.WIDTH(W), .PARITY_ODD(1'b1)) dut_o (
    .Clk(clk), .Reset(reset), .En(en), .Start(start), .Din(din),
    .Ready(ready_o), .Busy(busy_o), .SerOut(ser_o), .Done(done_o)
  );

  int           checks = 0;
  int           errors = 0;
  int           pos = -1;        // -1 idle, else index into the frame bit list
  logic [W+2:0] bits_e, bits_o;  // [0]=start, [1..W]=data, [W+1]=parity, [W+2]=stop
  logic         done_x = 1'b0;
  int           done_cnt = 0;
  int           cyc = 0;
  int           done_cyc[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W+2:0] frame_bits(input logic [W-1:0] d, input bit odd);
    logic p;
    int   ones;
    ones = $countones(d);
    p = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    return {1'b1, p, d, 1'b0};
  endfunction

  // One clock: drive inputs, advance the model on the edge, check all outputs mid-cycle.
  task automatic step(input logic r, input logic s, input logic e, input logic [W-1:0] d);
    reset = r;
    start = s;
    en    = e;
    din   = d;
    @(posedge clk);
    done_x = 1'b0;
    if (r) begin
      pos = -1;
    end else if (pos < 0) begin
      if (s) begin
        bits_e = frame_bits(d, 1'b0);
        bits_o = frame_bits(d, 1'b1);
        pos    = 0;
      end
    end else if (e) begin
      pos++;
      if (pos == W + 3) begin
        pos    = -1;
        done_x = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
    chk("ser_even", ser_e, (pos < 0) ? 1'b1 : bits_e[pos]);
    chk("ser_odd", ser_o, (pos < 0) ? 1'b1 : bits_o[pos]);
    chk("ready", ready_e, pos < 0);
    chk("busy", busy_e, pos >= 0);
    chk("ready_odd", ready_o, pos < 0);
    chk("done_even", done_e, done_x);
    chk("done_odd", done_o, done_x);
    if (done_e === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  endtask

  initial begin
    logic [0:10]  a5_seq;
    logic [W-1:0] rd;
    int           base;
    int           k;

    a5_seq = 11'b01010010101;

    // reset state
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    chk("rst_ser", ser_e, 1'b1);
    chk("rst_ready", ready_e, 1'b1);
    chk("rst_busy", busy_e, 1'b0);
    chk("rst_done", done_e, 1'b0);
    step(1'b0, 1'b0, 1'b1, '0);

    // basic frame A5, En tied high
    base = done_cnt;
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("a5_bit", ser_e, a5_seq[0]);
    chk("a5_ready_low", ready_e, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("a5_bit", ser_e, a5_seq[i]);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("a5_done_c12", done_e, 1'b1);
    chk("a5_ready_c12", ready_e, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("a5_done_once", done_cnt == base + 1, 1'b1);

    // odd parity with En every 4th cycle
    base = done_cnt;
    step(1'b0, 1'b1, 1'b0, 8'h01);
    for (int i = 1; i <= (W + 3) * 4 + 4; i++) begin
      step(1'b0, 1'b0, (i % 4 == 0), 8'h00);
      if (pos == W + 1) chk("odd_parity_01", ser_o, 1'b0);
    end
    chk("slow_done_once", done_cnt == base + 1, 1'b1);

    // Start/Din changes while busy are ignored
    base = done_cnt;
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < W + 4; i++) step(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("busy_ignore_one_frame", done_cnt == base + 1, 1'b1);

    // back-to-back with Start held high
    base = done_cnt;
    done_cyc.delete();
    step(1'b0, 1'b1, 1'b1, 8'h0F);
    for (int i = 2; i <= 2 * (W + 4); i++) step(1'b0, 1'b1, 1'b1, 8'hF0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("b2b_two_done", done_cnt == base + 2, 1'b1);
    if (done_cyc.size() == 2) chk("b2b_spacing", (done_cyc[1] - done_cyc[0]) == W + 4, 1'b1);
    else chk("b2b_done_list", 1'b0, 1'b1);

    // reset mid-frame during data bit 3, Start held through reset
    base = done_cnt;
    rd = 8'($urandom);
    step(1'b0, 1'b1, 1'b1, rd);
    for (int i = 2; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    chk("mid_rst_ser", ser_e, 1'b1);
    chk("mid_rst_ready", ready_e, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    chk("mid_rst_no_done", done_cnt == base, 1'b1);
    rd = 8'($urandom);
    step(1'b0, 1'b1, 1'b1, rd);
    for (int i = 2; i <= W + 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("after_rst_one_frame", done_cnt == base + 1, 1'b1);

    // randomized frames, En density and Start gaps
    for (int f = 0; f < 8; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
      step(1'b0, 1'b1, 1'($urandom), 8'($urandom));
      k = 0;
      while (!done_x && k < 300) begin
        step(1'b0, 1'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom));
        k++;
      end
      chk("rand_frame_done", done_x, 1'b1);
      step(1'b0, 1'b0, 1'b0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
